// File: rtl/cla_serial_adder.sv
// Digit-serial adder: one 4-bit carry-lookahead digit per clock, LSB first.
// Ports: clk, rst_n, in_valid/in_ready + a/b/cin in; out_valid/out_ready + sum/cout/ovf/pall out.
module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             pall
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             pacc_q;

    // Current digit always sits in the low nibble: operands shift right per digit.
    logic [3:0] ad, bd, g, p, c, dsum;
    logic       gg, pg, c4;

    always_comb begin
        ad   = a_q[3:0];
        bd   = b_q[3:0];
        g    = ad & bd;
        p    = ad ^ bd;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
        c4   = gg | (pg & c[0]);
        dsum = p ^ c;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            pacc_q  <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            pall    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        pacc_q  <= 1'b1;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (idx == k[IW-1:0]) begin
                            sum[4*k +: 4] <= dsum;
                        end
                    end
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    carry_q <= c4;
                    pacc_q  <= pacc_q & pg;
                    if (idx == LAST) begin
                        cout  <= c4;
                        // c[3] is the carry into bit WIDTH-1 on the top digit
                        ovf   <= c[3] ^ c4;
                        pall  <= pacc_q & pg;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder (WIDTH=16): directed cases,
// backpressure, mid-run reset and random operands against an arithmetic model.
module tb_cla_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        pall;

    int tests = 0;
    int fails = 0;
    int delivered = 0;

    cla_serial_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .pall     (pall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands and take the acceptance edge; scramble inputs after.
    task automatic send(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic);
        check("accept_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        cin      = ic;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
    endtask

    task automatic wait_valid();
        int cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'd4);
    endtask

    task automatic check_result(input logic [15:0] ea, input logic [15:0] eb,
                                input logic ec, input string tag);
        logic [16:0] full;
        logic        eovf;
        logic        epall;
        full  = 17'(ea) + 17'(eb) + 17'(ec);
        eovf  = (ea[15] == eb[15]) && (full[15] != ea[15]);
        epall = ((ea ^ eb) == 16'hFFFF);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sum"}, 32'(sum), 32'(full[15:0]));
        check({tag, ".cout"}, 32'(cout), 32'(full[16]));
        check({tag, ".ovf"}, 32'(ovf), 32'(eovf));
        check({tag, ".pall"}, 32'(pall), 32'(epall));
    endtask

    task automatic handshake();
        if (out_valid === 1'b1) delivered++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic op(input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input string tag);
        send(ia, ib, ic);
        wait_valid();
        check_result(ia, ib, ic, tag);
        handshake();
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        int          stall;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.sum", 32'(sum), 32'd0);
        check("rst.flags", 32'({cout, ovf, pall}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(16'h1234, 16'h4321, 1'b0, "d1");
        op(16'hFFFF, 16'h0000, 1'b1, "d2");
        op(16'h7FFF, 16'h0001, 1'b0, "d3");
        op(16'h8000, 16'h8000, 1'b0, "d4");

        // Backpressure with a competing request held on the input side
        send(16'h00FF, 16'h0001, 1'b0);
        wait_valid();
        check_result(16'h00FF, 16'h0001, 1'b0, "bp");
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.sum", 32'(sum), 32'h0100);
            check("bp.in_ready", 32'(in_ready), 32'd0);
        end
        handshake();
        op(16'hAAAA, 16'h5555, 1'b0, "bp2");

        // Asynchronous reset after the second digit edge
        send(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst.out_valid", 32'(out_valid), 32'd0);
        check("mrst.sum", 32'(sum), 32'd0);
        check("mrst.flags", 32'({cout, ovf, pall}), 32'd0);
        check("mrst.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("mrst.no_capture", 32'(in_ready), 32'd1);
        op(16'h0F0F, 16'h00F1, 1'b1, "mrst2");

        delivered = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            send(ra, rb, rc);
            wait_valid();
            check_result(ra, rb, rc, "rnd");
            stall = $urandom_range(0, 3);
            if (stall > 0) begin
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
                check_result(ra, rb, rc, "rnd_stall");
            end
            handshake();
        end
        check("rnd.delivered", 32'(delivered), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
